// File: rtl/prv32_muldiv_pkg.sv
// prv32_muldiv_defs: shared constants for the RV32M multiply/divide unit.
//   MD_XLEN / MD_CNT_W : datapath width and iteration counter width
//   F3_*               : RV32M funct3 encodings
//   ST_*               : FSM state encodings
package prv32_muldiv_defs;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/prv32_muldiv_divstep.sv
// prv32_divstep: one combinational restoring-division step.
//   i_rem  : partial remainder before the step (33b)
//   i_div  : divisor magnitude (32b)
//   i_bit  : next dividend bit shifted in
//   o_rem  : partial remainder after the step
//   o_q    : quotient bit produced by this step
module prv32_divstep (
  input  logic [32:0] i_rem,
  input  logic [31:0] i_div,
  input  logic        i_bit,
  output logic [31:0] o_rem,
  output logic        o_q
);

  logic [33:0] w_shifted;
  logic [31:0] w_diff;

  assign w_shifted = {i_rem, i_bit};
  assign o_q       = (w_shifted >= {2'b00, i_div});
  // When the subtraction is taken the true difference is below the divisor,
  // so the low 32 bits are exact.
  assign w_diff    = w_shifted[31:0] - i_div;
  assign o_rem     = o_q ? w_diff : w_shifted[31:0];

endmodule

// File: rtl/prv32_muldiv.sv
// prv32_muldiv: iterative RV32M multiply/divide unit (radix-2, one step per clock).
//   clk, rst_n : clock, async active-low reset
//   start      : request, sampled only in IDLE
//   funct3     : RV32M operation
//   a, b       : rs1 / rs2 operands, latched on accept
//   result     : final result, held until the next accepted request
//   busy       : high from the accepting edge until done
//   done       : one-cycle pulse, result valid in that cycle
//
// state | meaning
// IDLE  | waiting for start
// MUL   | 32 shift-add steps on the 64-bit accumulator
// DIV   | 32 restoring-divide steps
// FIX   | sign correction and word select into result (or special-case load)
// DONE  | done pulse cycle, start ignored
module prv32_muldiv
  import prv32_muldiv_defs::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  logic [2:0]       r_state;
  logic [2:0]       r_f3;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_acc;    // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [31:0]      r_opnd;   // multiplicand or divisor magnitude
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_special;
  logic [31:0]      r_result;
  logic             r_busy;
  logic             r_done;

  logic        w_a_sgn, w_b_sgn;
  logic [31:0] w_ma, w_mb;
  logic        w_div0, w_ovf;
  logic [31:0] w_spec;
  logic [32:0] w_msum;
  logic [31:0] w_drem;
  logic        w_dq;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_remf;
  logic [31:0] w_fix;

  assign w_a_sgn = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign w_b_sgn = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign w_ma = (w_a_sgn && a[31]) ? -a : a;
  assign w_mb = (w_b_sgn && b[31]) ? -b : b;

  assign w_div0 = funct3[2] && (b == 32'd0);
  assign w_ovf  = funct3[2] && !funct3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    w_spec = 32'd0;
    if (w_div0)
      w_spec = funct3[1] ? a : 32'hFFFF_FFFF;
    else if (w_ovf)
      w_spec = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  assign w_msum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);

  prv32_divstep u_divstep (
    .i_rem (({1'b0, r_acc[63:32]})),
    .i_div (r_opnd),
    .i_bit (r_acc[31]),
    .o_rem (w_drem),
    .o_q   (w_dq)
  );

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[31:0] : r_acc[31:0];
  assign w_remf = r_neg_r ? -r_acc[63:32] : r_acc[63:32];

  always_comb begin
    w_fix = r_acc[31:0];
    if (!r_special) begin
      case (r_f3)
        F3_MUL:                       w_fix = w_prod[31:0];
        F3_MULH, F3_MULHSU, F3_MULHU: w_fix = w_prod[63:32];
        F3_DIV, F3_DIVU:              w_fix = w_quo;
        default:                      w_fix = w_remf;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_f3      <= 3'd0;
      r_cnt     <= '0;
      r_acc     <= 64'd0;
      r_opnd    <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
      r_result  <= 32'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_f3      <= funct3;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_neg_q   <= (w_a_sgn && a[31]) ^ (w_b_sgn && b[31]);
            r_neg_r   <= w_a_sgn && a[31];
            r_opnd    <= funct3[2] ? w_mb : w_ma;
            r_special <= w_div0 || w_ovf;
            if (w_div0 || w_ovf) begin
              r_acc   <= {32'd0, w_spec};
              r_state <= ST_FIX;
            end else begin
              r_acc   <= {32'd0, funct3[2] ? w_ma : w_mb};
              r_state <= funct3[2] ? ST_DIV : ST_MUL;
            end
          end
        end
        ST_MUL: begin
          r_acc <= {w_msum, r_acc[31:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {CNT_W{1'b1}}) r_state <= ST_FIX;
        end
        ST_DIV: begin
          r_acc <= {w_drem, r_acc[30:0], w_dq};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {CNT_W{1'b1}}) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_result <= w_fix;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_prv32_muldiv.sv
module tb_prv32_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        busy;
  logic        done;

  typedef struct {
    string       nm;
    logic [31:0] exp;
    int          k;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  prv32_muldiv dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_result"}, result, e.exp);
        chk({e.nm, "_latency"}, cyc - e.k, e.lat);
        chk({e.nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] e, input int lat,
                       input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({nm, "_idle_timeout"}, 32'd1, 32'd0);
    funct3 = f;
    a      = x;
    b      = y;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    // scramble inputs to show the operands were latched
    a      = $urandom;
    b      = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    chk({nm, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
    if (push) q.push_back('{nm, e, cyc, lat});
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk({nm, "_drain_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    funct3 = 3'd0;
    a      = 32'd0;
    b      = 32'd0;
    #1;
    chk("reset_result", result, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // MUL 7 * -3, with a busy check late in the iteration
    issue("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1);
    repeat (32) @(posedge clk);
    #1;
    chk("mul_busy_edge_k32", {31'd0, busy}, 32'd1);
    drain("mul_7_m3");

    issue("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1);
    issue("mulh_ff",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b1);
    issue("mulhsu_ff",3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b1);

    issue("div_m20_3",  3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, 1'b1);
    issue("rem_m20_3",  3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, 1'b1);
    issue("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    issue("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b1);

    issue("divu_by0",  3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    issue("remu_by0",  3'b111, 32'd100, 32'd0, 32'd100, 1, 1'b1);
    issue("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    issue("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);

    // start during iteration is ignored
    issue("mul_3_5", 3'b000, 32'd3, 32'd5, 32'd15, 33, 1'b1);
    repeat (5) @(negedge clk);
    a      = 32'd100;
    b      = 32'd100;
    funct3 = 3'b100;
    start  = 1'b1;
    repeat (3) @(negedge clk);
    start  = 1'b0;
    drain("mul_3_5");
    repeat (3) @(negedge clk);
    chk("mul_3_5_result_held", result, 32'd15);

    // reset mid-iteration: immediate clear, no done pulse afterwards
    issue("mul_abort", 3'b000, 32'd6, 32'd7, 32'd42, 33, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("abort_no_pending", q.size(), 32'd0);

    issue("div_9_2", 3'b100, 32'd9, 32'd2, 32'd4, 33, 1'b1);
    drain("div_9_2");
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
